// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump reader.
package regdump_pkg;

    localparam int unsigned NREGS  = 32;
    localparam int unsigned RIDX_W = 5;
    localparam int unsigned DW     = 32;
    localparam int unsigned BEAT_W = RIDX_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_e;

    // Number of beats in a wrap-around range first..last (1..NREGS).
    function automatic logic [BEAT_W-1:0] beat_count(input logic [RIDX_W-1:0] first,
                                                     input logic [RIDX_W-1:0] last);
        logic [RIDX_W-1:0] span;
        span = last - first;
        return BEAT_W'(span) + BEAT_W'(1);
    endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a wrap-around register index range, samples the register file through
// one combinational read port and streams {index, data} beats over valid/ready.
// Optional running XOR checksum enabled by defining REGDUMP_CHECKSUM_EN.
module regfile_dump_reader
    import regdump_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        first_idx,
    input  logic [4:0]        last_idx,
    output logic              busy,
    output logic              done,
    output logic [4:0]        rf_raddr,
    input  logic [31:0]       rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_idx,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic [31:0]       checksum
);

    state_e              state_q, state_d;
    logic [RIDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [RIDX_W-1:0]   end_idx_q, end_idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                out_valid_q, out_valid_d;
    logic [RIDX_W-1:0]   out_idx_q, out_idx_d;
    logic [DW-1:0]       out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DW-1:0]       checksum_q, checksum_d;
`endif

    // Next-state and datapath update for the dump walk.
    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        end_idx_d   = end_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_idx_d  = first_idx;
                    end_idx_d  = last_idx;
                    busy_d     = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                out_data_d  = rf_rdata;
                out_idx_d   = cur_idx_q;
                out_last_d  = (cur_idx_q == end_idx_q);
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    checksum_d  = checksum_q ^ out_data_q;
`endif
                    if (out_last_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cur_idx_d = cur_idx_q + RIDX_W'(1);
                        state_d   = LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any dump in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_idx_q   <= '0;
            end_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            end_idx_q   <= end_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    // Running XOR of handshaken beat data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign rf_raddr  = cur_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural 32x32 register file.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic        busy;
    logic        done;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        out_last;
    logic [31:0] checksum;

    logic [31:0] regs [32];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    // Register file: combinational rs1 read, x0 hardwired to zero.
    assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : regs[rf_raddr];

    regfile_dump_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .busy      (busy),
        .done      (done),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .checksum  (checksum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_data(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : regs[idx];
    endfunction

    // Runs one dump from first f to last l and checks every beat plus completion.
    task automatic run_dump(input string name, input logic [4:0] f, input logic [4:0] l,
                            input int exp_beats, input int stall_at, input int stall_len,
                            input bit pulse_mid, input logic [31:0] exp_ck);
        int          beats;
        int          stalls;
        int          cyc;
        int          first_valid_cyc;
        bit          got_last;
        logic [4:0]  exp_idx;
        logic [4:0]  hold_idx;
        logic [31:0] hold_data;
        logic        hold_last;
        beats = 0; stalls = 0; cyc = 0; first_valid_cyc = -1; got_last = 1'b0;
        exp_idx = f; hold_idx = '0; hold_data = '0; hold_last = 1'b0;

        @(negedge clk);
        first_idx = f; last_idx = l; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; first_idx = 5'd9; last_idx = 5'd9;
        chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
        chk({name, "_valid_not_yet"}, 32'(out_valid), 32'd0);

        while (!got_last && cyc < 400) begin
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (stall_at >= 0 && int'(out_idx) == stall_at && stalls > 0) begin
                    chk({name, "_stall_idx"}, 32'(out_idx), 32'(hold_idx));
                    chk({name, "_stall_data"}, out_data, hold_data);
                    chk({name, "_stall_last"}, 32'(out_last), 32'(hold_last));
                end
                if (stall_at >= 0 && int'(out_idx) == stall_at && stalls < stall_len) begin
                    hold_idx = out_idx; hold_data = out_data; hold_last = out_last;
                    out_ready = 1'b0;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                    chk({name, "_idx"}, 32'(out_idx), 32'(exp_idx));
                    chk({name, "_data"}, out_data, ref_data(exp_idx));
                    chk({name, "_last"}, 32'(out_last), 32'(beats == exp_beats - 1));
                    beats++;
                    exp_idx = exp_idx + 5'd1;
                    if (out_last) got_last = 1'b1;
                end
            end
            if (done) chk({name, "_early_done"}, 32'(done), 32'd0);
            if (pulse_mid && beats == 2) begin
                start = 1'b1; first_idx = 5'd20; last_idx = 5'd20;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; out_ready = 1'b1;

        chk({name, "_got_last"}, 32'(got_last), 32'd1);
        chk({name, "_beats"}, 32'(beats), 32'(exp_beats));
        chk({name, "_first_valid_lat"}, 32'(first_valid_cyc), 32'd1);
        if (stall_at >= 0) chk({name, "_stalls"}, 32'(stalls), 32'(stall_len));
        chk({name, "_done_pulse"}, 32'(done), 32'd1);
        chk({name, "_busy_in_done"}, 32'(busy), 32'd0);
        chk({name, "_checksum"}, checksum, exp_ck);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_checksum_hold"}, checksum, exp_ck);
    endtask

    function automatic logic [31:0] ck_exp(input logic [31:0] v);
`ifdef REGDUMP_CHECKSUM_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; first_idx = '0; last_idx = '0; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        chk("rst_raddr", 32'(rf_raddr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1 full dump; XOR of 0x1000_0000+i over i=1..31 is 0x1000_0000
        for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
        run_dump("t1_full", 5'd0, 5'd31, 32, -1, 0, 1'b0, ck_exp(32'h1000_0000));

        // T2 backpressure at idx 3 for 5 cycles
        run_dump("t2_bp", 5'd0, 5'd5, 6, 3, 5, 1'b0,
                 ck_exp(32'h1000_0001 ^ 32'h1000_0002 ^ 32'h1000_0003 ^
                        32'h1000_0004 ^ 32'h1000_0005));

        // T3 wrap 30,31,0,1
        run_dump("t3_wrap", 5'd30, 5'd1, 4, -1, 0, 1'b0,
                 ck_exp(32'h1000_001E ^ 32'h1000_001F ^ 32'h1000_0001));

        // T4 single beat
        regs[7] = 32'hDEAD_BEEF;
        run_dump("t4_single", 5'd7, 5'd7, 1, -1, 0, 1'b0, ck_exp(32'hDEAD_BEEF));

        // T5 start pulsed mid-dump is ignored
        run_dump("t5_midstart", 5'd10, 5'd14, 5, -1, 0, 1'b1,
                 ck_exp(32'h1000_000A ^ 32'h1000_000B ^ 32'h1000_000C ^
                        32'h1000_000D ^ 32'h1000_000E));

        // T5 reset during SEND aborts with no done
        @(negedge clk);
        first_idx = 5'd2; last_idx = 5'd8; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t5_in_send", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t5_rst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("t5_after_rst_done", 32'(done), 32'd0);
        chk("t5_after_rst_busy", 32'(busy), 32'd0);
        run_dump("t5_restart", 5'd2, 5'd4, 3, -1, 0, 1'b0,
                 ck_exp(32'h1000_0002 ^ 32'h1000_0003 ^ 32'h1000_0004));

        // T6 checksum over a sparse file
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'h1; regs[2] = 32'h2; regs[3] = 32'h4;
        run_dump("t6_ck", 5'd0, 5'd31, 32, -1, 0, 1'b0, ck_exp(32'h0000_0007));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
